bpsk_modulator: RTL



---
 rtl/bpsk_modulator_if.sv | 11 +
 rtl/bpsk_modulator.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bpsk_modulator_if.sv
// Serial bit-stream port of the BPSK modulator.
interface bpsk_modulator_if;
  // A bit transfers on a cycle where s_valid & s_ready & en are all high; the
  // source holds s_bit/s_valid stable until then, and s_ready never depends on s_valid.
  logic s_bit;
  logic s_valid;
  logic s_ready;

  modport master (output s_bit, output s_valid, input s_ready);
  modport slave  (input s_bit, input s_valid, output s_ready);
endinterface

// File: rtl/bpsk_modulator.sv
// BPSK burst transmitter: DDS carrier, preamble, then one data bit per symbol.
// Optional build macro DIFF_ENC_EN selects differential symbol encoding.
module bpsk_modulator #(
  parameter logic [31:0] PHASE_INCR = 32'd919123001,
  parameter int          SYM_LEN    = 1000,
  parameter int          PRE_SYMS   = 64,
  parameter int          AMPL       = 2000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  bpsk_modulator_if.slave    s_if,
  output logic signed [11:0] dout,
  output logic               busy,
  output logic               underrun,
  output logic [1:0]         o_dbg_state
);
  localparam int SW = $clog2(SYM_LEN);
  localparam int PW = (PRE_SYMS > 1) ? $clog2(PRE_SYMS) : 1;
  localparam logic [SW-1:0] SYM_LAST = SW'(SYM_LEN - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_SYMS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PRE  = 2'd1,
    S_DATA = 2'd2
  } state_t;

  function automatic logic signed [11:0] sin_q(input int k);
    real r;
    r = real'(AMPL) * $sin(2.0 * 3.14159265358979323846 * real'(k) / 1024.0);
    return 12'($rtoi(r + 0.5));
  endfunction

  state_t             r_state, w_state_nxt;
  logic [SW-1:0]      r_sym_cnt, w_sym_cnt_nxt;
  logic [PW-1:0]      r_pre_cnt, w_pre_cnt_nxt;
  logic               r_sym, w_sym_nxt;
  logic [31:0]        r_acc;
  logic signed [11:0] r_lut;
  logic               r_idle_d;
  logic               r_sym_d;
  logic signed [11:0] r_dout;
  logic               r_busy;
  logic               w_ready;
  logic               w_underrun;
  logic               w_boundary;

  // Quarter-wave table 0..pi/2 inclusive; the other quadrants come from symmetry.
  logic signed [11:0] w_rom [0:256];
  for (genvar g = 0; g <= 256; g++) begin : g_rom
    assign w_rom[g] = sin_q(g);
  end

  logic [9:0]         w_addr;
  logic [8:0]         w_qidx;
  logic signed [11:0] w_qval;
  logic signed [11:0] w_lut;

  always_comb begin
    w_addr = r_acc[31:22];
    w_qidx = w_addr[8] ? (9'd256 - {1'b0, w_addr[7:0]}) : {1'b0, w_addr[7:0]};
    w_qval = w_rom[w_qidx];
    w_lut  = w_addr[9] ? -w_qval : w_qval;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sym_cnt_nxt = r_sym_cnt;
    w_pre_cnt_nxt = r_pre_cnt;
    w_sym_nxt     = r_sym;
    w_ready       = 1'b0;
    w_underrun    = 1'b0;
    w_boundary    = (r_sym_cnt == SYM_LAST);
    case (r_state)
      S_IDLE: begin
        w_sym_cnt_nxt = '0;
        w_pre_cnt_nxt = '0;
        w_sym_nxt     = 1'b0;
        if (s_if.s_valid) w_state_nxt = S_PRE;
      end
      S_PRE: begin
        w_sym_cnt_nxt = w_boundary ? '0 : r_sym_cnt + 1'b1;
        if (w_boundary) begin
          if (r_pre_cnt == PRE_LAST) w_ready = 1'b1;
          else                       w_pre_cnt_nxt = r_pre_cnt + 1'b1;
        end
      end
      S_DATA: begin
        w_sym_cnt_nxt = w_boundary ? '0 : r_sym_cnt + 1'b1;
        w_ready       = w_boundary;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_ready) begin
      if (s_if.s_valid) begin
        w_state_nxt = S_DATA;
`ifdef DIFF_ENC_EN
        w_sym_nxt   = r_sym ^ s_if.s_bit;
`else
        w_sym_nxt   = s_if.s_bit;
`endif
      end else begin
        w_underrun    = 1'b1;
        w_state_nxt   = S_IDLE;
        w_sym_cnt_nxt = '0;
        w_sym_nxt     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sym_cnt <= '0;
      r_pre_cnt <= '0;
      r_sym     <= 1'b0;
      r_acc     <= '0;
      r_lut     <= '0;
      r_idle_d  <= 1'b1;
      r_sym_d   <= 1'b0;
      r_dout    <= '0;
      r_busy    <= 1'b0;
    end else if (en) begin
      r_state   <= w_state_nxt;
      r_sym_cnt <= w_sym_cnt_nxt;
      r_pre_cnt <= w_pre_cnt_nxt;
      r_sym     <= w_sym_nxt;
      r_acc     <= r_acc + PHASE_INCR;
      // Controls ride alongside the LUT stage so dout lines up with the phase that made it.
      r_lut     <= w_lut;
      r_idle_d  <= (r_state == S_IDLE);
      r_sym_d   <= r_sym;
      r_dout    <= r_idle_d ? 12'sd0 : (r_sym_d ? -r_lut : r_lut);
      r_busy    <= (w_state_nxt != S_IDLE);
    end
  end

  assign s_if.s_ready = w_ready & en;
  assign underrun     = w_underrun & en;
  assign dout         = r_dout;
  assign busy         = r_busy;
  assign o_dbg_state  = r_state;
endmodule
